// File: rtl/controller_responder_m.sv
// -----------------------------------------------------------------------------
// controller_responder_m
//
// Responder side of a latch/clock serial button-pad protocol. While the
// initiator holds controller_latch high, the button levels are loaded in
// parallel into a shift register. After the latch falls, every rising edge
// of controller_clk moves the register one place toward bit 0. The register
// bit 0 is presented, inverted, on controller_data_out_B. When NUM_BUTTONS
// bits have gone out, read_done pulses for one cycle and the block parks in
// DONE until the next latch.
//
// Parameters
//   NUM_BUTTONS          serial bits per read frame (1..15)
//
// Ports
//   cpu_clk              the single clock; all state updates on its rising edge
//   rst                  synchronous, active-high reset
//   buttons_in           button levels, 1 = pressed; bit 0 is shifted out first
//   controller_latch     latch from the initiator; high = parallel load
//   controller_clk       serial clock from the initiator; idles high
//   controller_data_out_B serial data, active-low (0 = pressed), registered
//   shift_count          bits shifted since the latch fell (saturates)
//   read_done            one-cycle pulse when the last bit has been shifted
//   state                IDLE=0, LOAD=1, SHIFT=2, DONE=3
//
// Build option
//   CONTROLLER_RESPONDER_SYNC_EN  when defined, controller_latch and
//   controller_clk pass through two-flop synchronizers first, which adds two
//   cycles to every input-to-output latency. When undefined, both inputs are
//   sampled directly.
// -----------------------------------------------------------------------------
module controller_responder_m #(
  parameter int NUM_BUTTONS = 8
) (
  input  logic                   cpu_clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  input  logic                   controller_latch,
  input  logic                   controller_clk,
  output logic                   controller_data_out_B,
  output logic [3:0]             shift_count,
  output logic                   read_done,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_COUNT = 4'(NUM_BUTTONS);
  // Count value just before the final shift of a frame.
  localparam logic [3:0] PRE_LAST   = 4'(NUM_BUTTONS - 1);

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
  logic latch_s;
  logic clk_s;

`ifdef CONTROLLER_RESPONDER_SYNC_EN
  // Two-flop synchronizers; bit 1 is the synchronized output. The clock
  // chain resets to 1 so an idle-high serial clock sees no edge after reset.
  logic [1:0] latch_sync_q;
  logic [1:0] clk_sync_q;

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      latch_sync_q <= 2'b00;
      clk_sync_q   <= 2'b11;
    end else begin
      latch_sync_q <= {latch_sync_q[0], controller_latch};
      clk_sync_q   <= {clk_sync_q[0], controller_clk};
    end
  end

  assign latch_s = latch_sync_q[1];
  assign clk_s   = clk_sync_q[1];
`else
  assign latch_s = controller_latch;
  assign clk_s   = controller_clk;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q,    state_d;
  logic [NUM_BUTTONS-1:0] shift_q,    shift_d;
  logic [3:0]             count_q,    count_d;
  logic                   done_q,     done_d;
  logic                   data_out_q, data_out_d;
  logic                   clk_prev_q;
  logic                   clk_rise;

  // Rising edge of the serial clock as seen across two consecutive samples.
  assign clk_rise = clk_s & ~clk_prev_q;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    count_d    = count_q;
    done_d     = 1'b0;
    data_out_d = 1'b1;

    if (latch_s) begin
      // Latch has priority over everything, including a same-cycle clock
      // edge, and keeps reloading for as long as it stays high.
      state_d = LOAD;
      shift_d = buttons_in;
      count_d = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          // Any edge seen in this cycle is dropped on purpose.
          state_d = SHIFT;
          count_d = '0;
        end
        SHIFT: begin
          if (clk_rise && (count_q != LAST_COUNT)) begin
            // Logical shift fills the vacated top bit with "not pressed".
            shift_d = shift_q >> 1;
            count_d = count_q + 4'd1;
            if (count_q == PRE_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;  // IDLE and DONE ignore the serial clock.
      endcase
    end

    // Data follows the register only while a frame is live; otherwise the
    // line rests at "not pressed".
    if ((state_q == LOAD) || (state_q == SHIFT)) begin
      data_out_d = ~shift_q[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      data_out_q <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      clk_prev_q <= clk_s;
    end
  end

  assign controller_data_out_B = data_out_q;
  assign shift_count           = count_q;
  assign read_done             = done_q;
  assign state                 = state_q;

endmodule

// File: doc/controller_responder_m.md
CONTROLLER_RESPONDER_M -- requirements
Module: controller_responder_m

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 8: number of serial bits per read frame, range 1..15.
REQ-002 SHALL have port cpu_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port buttons_in, input, NUM_BUTTONS: button levels, 1 = pressed; bit 0 is shifted out first.
REQ-005 SHALL have port controller_latch, input, 1: latch from the initiator; high = parallel load.
REQ-006 SHALL have port controller_clk, input, 1: serial clock from the initiator, idles high; a rising edge advances one bit.
REQ-007 SHALL have port controller_data_out_B, output, 1: serial data, active-low (0 = pressed).
REQ-008 SHALL have port shift_count, output, 4: bits shifted since latch fell.
REQ-009 SHALL have port read_done, output, 1: one-cycle pulse when the last bit has been shifted.
REQ-010 SHALL have port state, output, 2: IDLE=0, LOAD=1, SHIFT=2, DONE=3.

Function
REQ-011 The block SHALL sample controller_latch and controller_clk once per cpu_clk cycle and detect a clock rising edge as previous sample 0 and current sample 1.
REQ-012 In any state, a latch sample of 1 SHALL move the block to LOAD, clear shift_count and load buttons_in into the shift register on every cycle the latch stays high.
REQ-013 In LOAD, a latch sample of 0 SHALL move the block to SHIFT with shift_count 0.
REQ-014 In SHIFT, each detected clock edge SHALL shift the register one place toward bit 0, fill the vacated top bit with 0 (not pressed), and increment shift_count.
REQ-015 When shift_count reaches NUM_BUTTONS, the block SHALL enter DONE and assert read_done for exactly that one cycle.
REQ-016 In DONE and IDLE, clock edges SHALL be ignored and controller_data_out_B SHALL stay 1.
REQ-017 controller_data_out_B SHALL be a register equal to the inverse of shift-register bit 0, updated one cycle after the load or shift that changed that bit.
REQ-018 If a latch high and a clock edge are sampled in the same cycle, the latch SHALL win and the edge SHALL be discarded.
REQ-019 Clock edges sampled in LOAD SHALL be discarded.
REQ-020 shift_count SHALL saturate at NUM_BUTTONS and never wrap.
REQ-021 A change on buttons_in during SHIFT SHALL NOT affect the frame in progress.

Reset
REQ-022 On rst, the block SHALL set state IDLE, shift register 0, shift_count 0, read_done 0 and controller_data_out_B 1.
REQ-023 On rst, the previous clock sample SHALL be set to 1, so no edge is detected on the first cycle after reset.
REQ-024 Reset during LOAD or SHIFT SHALL abort the frame, and a new latch high SHALL be required before any data is shifted out.

Configuration
REQ-025 With CONTROLLER_RESPONDER_SYNC_EN defined, the block SHALL pass controller_latch and controller_clk through two-flop synchronizers (reset values 0 and 1 respectively), adding exactly 2 cycles to every input-to-output latency.
REQ-026 Without CONTROLLER_RESPONDER_SYNC_EN, the block SHALL sample both inputs directly with no synchronizer stage and no added latency.

Verification
REQ-027 The bench SHALL cover: buttons_in=8'b0000_0101, latch pulse, then 8 clock edges -> controller_data_out_B sequence 0,1,0,1,1,1,1,1; read_done pulses once after edge 8; state=DONE.
REQ-028 The bench SHALL cover: after a full frame, 3 more clock edges -> controller_data_out_B stays 1, shift_count stays 8, no further read_done.
REQ-029 The bench SHALL cover: latch rising after 4 edges of a frame with buttons_in=8'hFF -> state LOAD, shift_count 0, controller_data_out_B=0 one cycle later.
REQ-030 The bench SHALL cover: latch high and a clock rising edge sampled in the same cycle -> no shift, shift_count 0, state LOAD.
REQ-031 The bench SHALL cover: rst asserted after edge 3 -> next cycle state IDLE, controller_data_out_B 1; clock edges ignored until the next latch.
REQ-032 The bench SHALL cover: with CONTROLLER_RESPONDER_SYNC_EN defined, latch fall to first bit change -> latency equals the non-synchronized latency plus 2 cycles.
